// File: rtl/serial_tx.sv
// serial_tx: UART-style 8N1 transmitter, terminal stage of the transmit chain.
// Takes one word from the upstream stage over a 4-phase valid/busy handshake
// and shifts it out LSB first, framed by one low start bit and one high stop bit.
// Each bit is held for DIV = CLK_FREQ / BAUD_RATE clock cycles.
//
// Ports:
//   clk         system clock (single clock domain)
//   rst_n       synchronous active-low reset
//   data_in     word from upstream, sampled only on the capture edge
//   di_valid    upstream request, level-sensitive
//   full_empty  acknowledge to upstream: 1 = full/busy, 0 = empty/ready
//   tx          serial line, idles high
//   tx_busy     high while a frame (start..stop) is on the line
module serial_tx #(
   parameter int unsigned CLK_FREQ  = 48_000_000,
   parameter int unsigned BAUD_RATE = 115_200,
   parameter int unsigned Nd        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [Nd-1:0] data_in,
   input  logic          di_valid,
   output logic          full_empty,
   output logic          tx,
   output logic          tx_busy
);

   localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
   localparam int unsigned BaudW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BitW  = (Nd > 1) ? $clog2(Nd) : 1;

   localparam logic [BaudW-1:0] BaudReload = BaudW'(DIV - 1);
   localparam logic [BitW-1:0]  BitLast    = BitW'(Nd - 1);

   if (DIV < 2) begin : g_div_check
      $error("serial_tx: CLK_FREQ / BAUD_RATE must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q;
   logic [BaudW-1:0] baud_cnt_q;
   logic [BitW-1:0]  bit_cnt_q;
   logic [Nd-1:0]    shreg_q;

   logic [Nd-1:0]    shreg_next;
   logic             baud_zero;
   logic             frame_done;

   assign shreg_next = shreg_q >> 1;
   assign baud_zero  = (baud_cnt_q == '0);
   // Edge that ends the stop bit; the handshake may release on this same edge.
   assign frame_done = (state_q == StStop) && baud_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         tx         <= 1'b1;
         full_empty <= 1'b0;
         tx_busy    <= 1'b0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         shreg_q    <= '0;
      end else begin
         // Release only once the line is idle and upstream has dropped its request;
         // a request still held after the frame keeps full_empty high (no resend).
         if ((state_q == StIdle || frame_done) && !di_valid) begin
            full_empty <= 1'b0;
         end

         unique case (state_q)
            StIdle: begin
               if (di_valid && !full_empty) begin
                  shreg_q    <= data_in;
                  full_empty <= 1'b1;
                  tx         <= 1'b0;
                  tx_busy    <= 1'b1;
                  baud_cnt_q <= BaudReload;
                  state_q    <= StStart;
               end
            end

            StStart: begin
               if (baud_zero) begin
                  tx         <= shreg_q[0];
                  bit_cnt_q  <= '0;
                  baud_cnt_q <= BaudReload;
                  state_q    <= StData;
               end else begin
                  baud_cnt_q <= baud_cnt_q - BaudW'(1);
               end
            end

            StData: begin
               if (baud_zero) begin
                  baud_cnt_q <= BaudReload;
                  if (bit_cnt_q == BitLast) begin
                     tx      <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     shreg_q   <= shreg_next;
                     tx        <= shreg_next[0];
                     bit_cnt_q <= bit_cnt_q + BitW'(1);
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q - BaudW'(1);
               end
            end

            StStop: begin
               if (baud_zero) begin
                  tx_busy <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  baud_cnt_q <= baud_cnt_q - BaudW'(1);
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx at DIV = 4 (CLK_FREQ = 64, BAUD_RATE = 16), Nd = 8.
// Bytes are pushed to a scoreboard queue when offered upstream; an independent
// line receiver decodes frames from tx and pops/compares them.
module tb_serial_tx;

   localparam int unsigned Div      = 4;
   localparam int unsigned NBits    = 8;
   localparam int unsigned FrameLen = (NBits + 2) * Div;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NBits-1:0] data_in = '0;
   logic             di_valid = 1'b0;
   logic             full_empty;
   logic             tx;
   logic             tx_busy;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [7:0] expq[$];
   logic [7:0] chain_bytes [3] = '{8'hA5, 8'h3C, 8'hFF};

   serial_tx #(
      .CLK_FREQ (64),
      .BAUD_RATE(16),
      .Nd       (NBits)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .di_valid  (di_valid),
      .full_empty(full_empty),
      .tx        (tx),
      .tx_busy   (tx_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected line level i cycles into a frame carrying byte b.
   function automatic logic exp_bit(input logic [7:0] b, input int i);
      int k;
      k = i / Div;
      if (k == 0) return 1'b0;
      if (k <= NBits) return b[k-1];
      return 1'b1;
   endfunction

   // ---------------- line receiver / scoreboard consumer ----------------
   bit          mon_act = 1'b0;
   int unsigned mon_idx = 0;
   logic [7:0]  mon_byte = '0;
   int unsigned gap = 99;
   int unsigned busy_run = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_act  = 1'b0;
         gap      = 99;
         busy_run = 0;
      end else begin
         if (tx_busy === 1'b1) begin
            busy_run++;
         end else if (busy_run != 0) begin
            check_eq("busy_len", busy_run, FrameLen);
            busy_run = 0;
         end

         if (!mon_act) begin
            if (tx === 1'b0) begin
               check_eq("idle_gap_ge2", 32'(gap >= 2), 1);
               mon_act = 1'b1;
               mon_idx = 0;
            end else begin
               gap++;
            end
         end

         if (mon_act) begin
            if (mon_idx % Div == Div / 2) begin
               int k;
               k = mon_idx / Div;
               if (k == 0) begin
                  check_eq("start_bit", tx, 0);
               end else if (k <= NBits) begin
                  mon_byte[k-1] = tx;
               end else begin
                  check_eq("stop_bit", tx, 1);
                  check_eq("sb_nonempty", 32'(expq.size() > 0), 1);
                  if (expq.size() > 0) check_eq("rx_byte", mon_byte, expq.pop_front());
               end
            end
            if (mon_idx == FrameLen - 1) begin
               mon_act = 1'b0;
               gap     = 0;
            end else begin
               mon_idx++;
            end
         end
      end
   end

   // ---------------- upstream driver ----------------
   // Waits for ready, then one extra cycle like a registered upstream stage.
   task automatic wait_ready();
      int n;
      n = 0;
      while (full_empty !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check_eq("ready_timeout", full_empty, 0);
      @(negedge clk);
   endtask

   // Offers byte b; returns on the first negedge after the capture edge.
   task automatic launch(input logic [7:0] b, input bit push);
      wait_ready();
      data_in  = b;
      di_valid = 1'b1;
      if (push) expq.push_back(b);
      @(negedge clk);
      check_eq("cap_fe", full_empty, 1);
      check_eq("cap_tx", tx, 0);
      check_eq("cap_busy", tx_busy, 1);
   endtask

   // Cycle-exact line check from the first start-bit cycle to the first idle cycle.
   task automatic trace_frame(input logic [7:0] b);
      for (int i = 0; i < FrameLen; i++) begin
         check_eq($sformatf("tx_cyc%0d", i), tx, exp_bit(b, i));
         if (i == 0) di_valid = 1'b0;
         @(negedge clk);
      end
      check_eq("end_busy", tx_busy, 0);
      check_eq("end_fe", full_empty, 0);
      check_eq("end_tx", tx, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held 3 cycles with a pending request.
      di_valid = 1'b1;
      data_in  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_tx", tx, 1);
         check_eq("rst_fe", full_empty, 0);
         check_eq("rst_busy", tx_busy, 0);
      end
      rst_n = 1'b1;
      expq.push_back(8'hA5);
      @(negedge clk);
      check_eq("post_rst_fe", full_empty, 1);
      check_eq("post_rst_tx", tx, 0);
      di_valid = 1'b0;

      // Single byte, cycle-exact.
      launch(8'h55, 1'b1);
      trace_frame(8'h55);

      // Request dropped mid-frame: acknowledge held until the stop bit ends.
      launch(8'hC3, 1'b1);
      repeat (2) @(negedge clk);
      di_valid = 1'b0;
      for (int n = 0; n < 100 && tx_busy === 1'b1; n++) begin
         check_eq("hold_fe", full_empty, 1);
         @(negedge clk);
      end
      check_eq("rel_busy", tx_busy, 0);
      check_eq("rel_fe", full_empty, 0);

      // Request held 60 cycles: no resend, release one edge after it drops.
      launch(8'h96, 1'b1);
      for (int i = 0; i < 60; i++) begin
         if (i >= FrameLen) begin
            check_eq("held_busy", tx_busy, 0);
            check_eq("held_fe", full_empty, 1);
            check_eq("held_tx", tx, 1);
         end
         @(negedge clk);
      end
      check_eq("held_fe_end", full_empty, 1);
      di_valid = 1'b0;
      @(negedge clk);
      check_eq("drop_fe", full_empty, 0);
      check_eq("drop_busy", tx_busy, 0);

      // Back-to-back chain of bytes.
      foreach (chain_bytes[j]) begin
         launch(chain_bytes[j], 1'b1);
         di_valid = 1'b0;
      end

      // data_in changed after capture must not affect the frame.
      launch(8'h0F, 1'b1);
      data_in  = 8'hF0;
      di_valid = 1'b0;

      // Reset during data bit 3 discards the byte.
      launch(8'h5A, 1'b0);
      di_valid = 1'b0;
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("midrst_tx", tx, 1);
      check_eq("midrst_fe", full_empty, 0);
      check_eq("midrst_busy", tx_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      launch(8'h81, 1'b1);
      trace_frame(8'h81);

      for (int n = 0; n < 200 && tx_busy !== 1'b0; n++) @(negedge clk);
      repeat (4) @(negedge clk);
      check_eq("sb_drained", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
